// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//   Receiving end of the systolic array result stream. Result rows arrive
//   over a valid/ready handshake, are buffered in a small show-ahead row
//   FIFO and are written one row per SRAM word at base + row*stride.
//   When the SRAM port stalls the FIFO fills and the array is backpressured.
//
// Optional feature macro: RESULT_DRAIN_RELU_EN
//   Defined   : when the latched cfg_relu is 1, negative lanes are written
//               as zero (clamp sits on the FIFO output path, no latency).
//   Undefined : cfg_relu is ignored, data is written bit-exact.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              begin a drain job (sampled in IDLE only)
//   cfg_base_addr      first row address          (latched on start)
//   cfg_stride         address increment per row  (latched on start)
//   cfg_rows           rows to accept             (latched on start)
//   cfg_relu           ReLU select                (latched on start)
//   busy               high while the job is running or flushing
//   done               one-cycle completion pulse
//   result_valid/ready/data   row input handshake, lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//   mem_wr_en/addr/data/ready SRAM write port, same lane packing
// ---------------------------------------------------------------------------
module systolic_result_drain #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]            cfg_stride,
   input  logic [15:0]                      cfg_rows,
   input  logic                             cfg_relu,
   output logic                             busy,
   output logic                             done,
   input  logic                             result_valid,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  result_data,
   output logic                             result_ready,
   output logic                             mem_wr_en,
   output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
   output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  mem_wr_data,
   input  logic                             mem_wr_ready
);

   localparam int unsigned DW = ARRAY_SIZE * ACC_WIDTH;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_stride;
   logic [15:0]           r_rows;
   logic [15:0]           r_acc_cnt;
   logic [15:0]           r_wr_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic [DW-1:0]         r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         w_count_next;
   logic [15:0]           w_acc_next;
   logic [15:0]           w_wr_next;
   logic [DW-1:0]         w_head;
   logic [DW-1:0]         w_out;

   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_ready      = (r_state == S_RUN) && !w_full && (r_acc_cnt < r_rows);
   assign w_push       = result_valid && w_ready;
   assign w_pop        = !w_empty && mem_wr_ready;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   assign w_acc_next   = r_acc_cnt + 16'(w_push);
   assign w_wr_next    = r_wr_cnt + 16'(w_pop);
   assign w_head       = r_mem[r_rptr];

`ifdef RESULT_DRAIN_RELU_EN
   logic r_relu;

   always_comb begin
      w_out = w_head;
      if (r_relu) begin
         for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
            if (w_head[c*ACC_WIDTH + ACC_WIDTH - 1]) begin
               w_out[c*ACC_WIDTH +: ACC_WIDTH] = '0;
            end
         end
      end
   end
`else
   logic w_unused_relu;

   assign w_unused_relu = cfg_relu;
   assign w_out         = w_head;
`endif

   // Row storage carries no reset; stale contents are never visible because
   // the write data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= result_data;
      end
   end

   // State transitions look at next-cycle counts so that FLUSH is entered on
   // the final accept edge and DONE on the final write edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_stride  <= '0;
         r_rows    <= '0;
         r_acc_cnt <= '0;
         r_wr_cnt  <= '0;
         r_addr    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
`ifdef RESULT_DRAIN_RELU_EN
         r_relu    <= 1'b0;
`endif
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
            r_addr <= r_addr + r_stride;
         end
         r_count   <= w_count_next;
         r_acc_cnt <= w_acc_next;
         r_wr_cnt  <= w_wr_next;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_stride  <= cfg_stride;
                  r_rows    <= cfg_rows;
                  r_addr    <= cfg_base_addr;
                  r_acc_cnt <= '0;
                  r_wr_cnt  <= '0;
`ifdef RESULT_DRAIN_RELU_EN
                  r_relu    <= cfg_relu;
`endif
                  r_state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_acc_next == r_rows) begin
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if ((w_wr_next == r_rows) && (w_count_next == '0)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy         = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign done         = (r_state == S_DONE);
   assign result_ready = w_ready;
   assign mem_wr_en    = !w_empty;
   assign mem_wr_addr  = r_addr;
   assign mem_wr_data  = w_empty ? '0 : w_out;

endmodule

// File: tb/tb_systolic_result_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_drain
//   Directed bench for systolic_result_drain with default parameters.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_systolic_result_drain;

   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [9:0]      cfg_base_addr;
   logic [9:0]      cfg_stride;
   logic [15:0]     cfg_rows;
   logic            cfg_relu;
   logic            busy;
   logic            done;
   logic            result_valid;
   logic [DW-1:0]   result_data;
   logic            result_ready;
   logic            mem_wr_en;
   logic [9:0]      mem_wr_addr;
   logic [DW-1:0]   mem_wr_data;
   logic            mem_wr_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   systolic_result_drain #(
      .ARRAY_SIZE (4),
      .ACC_WIDTH  (32),
      .ADDR_WIDTH (10),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_stride    (cfg_stride),
      .cfg_rows      (cfg_rows),
      .cfg_relu      (cfg_relu),
      .busy          (busy),
      .done          (done),
      .result_valid  (result_valid),
      .result_data   (result_data),
      .result_ready  (result_ready),
      .mem_wr_en     (mem_wr_en),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_wr_ready  (mem_wr_ready)
   );

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (result_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", result_ready); end
      total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
      total++; if (mem_wr_addr !== 10'h000) begin bad++; $display("FAIL reset_wr_addr got=%h exp=000", mem_wr_addr); end
      total++; if (mem_wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", mem_wr_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // base 0x010, stride 1, 4 rows of {1},{2},{3},{4} in every lane
   task automatic test_basic();
      logic [DW-1:0] exp_d;
      logic [9:0]    exp_a;
      int sent = 0, got = 0, last_wr = -10, done_cnt = 0;
      bit fin = 1'b0;
      mem_wr_ready  = 1'b1;
      cfg_base_addr = 10'h010;
      cfg_stride    = 10'd1;
      cfg_rows      = 16'd4;
      cfg_relu      = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
      for (int c = 0; c < 40 && !fin; c++) begin
         if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (c != last_wr + 1) begin bad++; $display("FAIL basic_done_time got_cycle=%0d exp_cycle=%0d", c, last_wr + 1); end
         end else if (done_cnt > 0) begin
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after_done got=%b exp=0", busy); end
            fin = 1'b1;
         end
         if (mem_wr_en === 1'b1 && mem_wr_ready) begin
            exp_a = 10'h010 + 10'(got);
            exp_d = {4{32'(got + 1)}};
            total++;
            if (mem_wr_addr !== exp_a || mem_wr_data !== exp_d) begin
               bad++; $display("FAIL basic_write%0d got=%h/%h exp=%h/%h", got, mem_wr_addr, mem_wr_data, exp_a, exp_d);
            end
            got++;
            last_wr = c;
         end
         result_valid = (sent < 4);
         result_data  = {4{32'(sent + 1)}};
         if (result_valid && result_ready === 1'b1) sent++;
         @(negedge clk);
      end
      result_valid = 1'b0;
      total++;
      if (got != 4 || done_cnt != 1 || !fin) begin
         bad++; $display("FAIL basic_summary writes=%0d done_pulses=%0d finished=%0d exp 4/1/1", got, done_cnt, fin);
      end
   endtask

   // 8 rows, SRAM stalled for 10 cycles with valid held high
   task automatic test_backpressure();
      logic [DW-1:0] exp_d;
      logic [9:0]    exp_a;
      int sent = 0, got = 0;
      bit dn = 1'b0;
      mem_wr_ready  = 1'b0;
      cfg_base_addr = 10'h020;
      cfg_stride    = 10'd4;
      cfg_rows      = 16'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 60 && !dn; c++) begin
         mem_wr_ready = (c >= 10);
         if (c == 4 || c == 9) begin
            total++;
            if (sent != 4 || result_ready !== 1'b0) begin
               bad++; $display("FAIL bp_stall_accepts cycle=%0d got=%0d ready=%b exp=4 ready=0", c, sent, result_ready);
            end
         end
         if (done === 1'b1) dn = 1'b1;
         if (mem_wr_en === 1'b1 && mem_wr_ready) begin
            exp_a = 10'h020 + 10'(got * 4);
            exp_d = {4{32'h100 + 32'(got)}};
            total++;
            if (mem_wr_addr !== exp_a || mem_wr_data !== exp_d) begin
               bad++; $display("FAIL bp_write%0d got=%h/%h exp=%h/%h", got, mem_wr_addr, mem_wr_data, exp_a, exp_d);
            end
            got++;
         end
         result_valid = (sent < 8);
         result_data  = {4{32'h100 + 32'(sent)}};
         if (result_valid && result_ready === 1'b1) sent++;
         @(negedge clk);
      end
      result_valid = 1'b0;
      total++;
      if (got != 8 || sent != 8 || !dn) begin
         bad++; $display("FAIL bp_summary writes=%0d accepts=%0d done=%0d exp 8/8/1", got, sent, dn);
      end
   endtask

   // base 0x3FE, stride 2, 3 rows: addresses wrap to 0x000 and 0x002
   task automatic test_wrap();
      logic [9:0] exp_a [3] = '{10'h3FE, 10'h000, 10'h002};
      int sent = 0, got = 0;
      bit dn = 1'b0;
      mem_wr_ready  = 1'b1;
      cfg_base_addr = 10'h3FE;
      cfg_stride    = 10'd2;
      cfg_rows      = 16'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 30 && !dn; c++) begin
         if (done === 1'b1) dn = 1'b1;
         if (mem_wr_en === 1'b1 && got < 3) begin
            total++;
            if (mem_wr_addr !== exp_a[got] || mem_wr_data !== {4{32'hA0 + 32'(got)}}) begin
               bad++; $display("FAIL wrap_write%0d got=%h exp=%h", got, mem_wr_addr, exp_a[got]);
            end
            got++;
         end
         result_valid = (sent < 3);
         result_data  = {4{32'hA0 + 32'(sent)}};
         if (result_valid && result_ready === 1'b1) sent++;
         @(negedge clk);
      end
      result_valid = 1'b0;
      total++;
      if (got != 3 || !dn) begin bad++; $display("FAIL wrap_summary writes=%0d done=%0d exp 3/1", got, dn); end
   endtask

   // rows=0: done in the third cycle after start, no handshakes at all
   task automatic test_zero_rows();
      int done_at = -1;
      int rdy_hi = 0, wr_hi = 0;
      mem_wr_ready  = 1'b1;
      cfg_base_addr = 10'h055;
      cfg_stride    = 10'd1;
      cfg_rows      = 16'd0;
      result_valid  = 1'b1;
      result_data   = {4{32'hDEAD_BEEF}};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (done === 1'b1 && done_at < 0) done_at = k;
         if (result_ready === 1'b1) rdy_hi++;
         if (mem_wr_en === 1'b1) wr_hi++;
         @(negedge clk);
      end
      result_valid = 1'b0;
      total++; if (done_at != 3) begin bad++; $display("FAIL zero_done_time got=%0d exp=3", done_at); end
      total++; if (rdy_hi != 0) begin bad++; $display("FAIL zero_ready got=%0d exp=0", rdy_hi); end
      total++; if (wr_hi != 0) begin bad++; $display("FAIL zero_wr_en got=%0d exp=0", wr_hi); end
   endtask

   // lanes {-5, 7, 0x80000000, 0}; first with cfg_relu=1, then cfg_relu=0
   task automatic test_relu();
      logic [DW-1:0] raw   = {32'h0000_0000, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFB};
      logic [DW-1:0] clamp = {32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000};
      logic [DW-1:0] exp_d;
      mem_wr_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         int sent = 0, seen = 0;
         bit dn = 1'b0;
         cfg_relu      = (j == 0);
         cfg_base_addr = 10'h100;
         cfg_stride    = 10'd1;
         cfg_rows      = 16'd1;
`ifdef RESULT_DRAIN_RELU_EN
         exp_d = (j == 0) ? clamp : raw;
`else
         exp_d = raw;
         if (clamp == raw) exp_d = clamp;
`endif
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 12 && !dn; c++) begin
            if (done === 1'b1) dn = 1'b1;
            if (mem_wr_en === 1'b1) begin
               seen++;
               total++;
               if (mem_wr_data !== exp_d) begin
                  bad++; $display("FAIL relu_data relu=%0d got=%h exp=%h", cfg_relu, mem_wr_data, exp_d);
               end
            end
            result_valid = (sent == 0);
            result_data  = raw;
            if (result_valid && result_ready === 1'b1) sent++;
            @(negedge clk);
         end
         result_valid = 1'b0;
         total++;
         if (seen != 1 || !dn) begin bad++; $display("FAIL relu_summary relu=%0d writes=%0d done=%0d exp 1/1", j == 0, seen, dn); end
      end
      cfg_relu = 1'b0;
   endtask

   // 2 of 4 rows buffered with the SRAM stalled, then a 1-cycle reset
   task automatic test_reset_mid();
      int done_hi = 0, wr_hi = 0;
      mem_wr_ready  = 1'b0;
      cfg_base_addr = 10'h200;
      cfg_stride    = 10'd1;
      cfg_rows      = 16'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         result_valid = 1'b1;
         result_data  = {4{32'h5A5A_0000 + 32'(c)}};
         @(negedge clk);
      end
      result_valid = 1'b0;
      total++;
      if (mem_wr_en !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre got wr_en=%b busy=%b exp 1/1", mem_wr_en, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_wr_ready = 1'b1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result_ready !== 1'b0 || mem_wr_en !== 1'b0 ||
          mem_wr_addr !== 10'h000 || mem_wr_data !== '0) begin
         bad++; $display("FAIL rstmid_outputs got busy=%b done=%b rdy=%b en=%b addr=%h data=%h exp all 0",
                         busy, done, result_ready, mem_wr_en, mem_wr_addr, mem_wr_data);
      end
      for (int k = 0; k < 5; k++) begin
         if (done === 1'b1) done_hi++;
         if (mem_wr_en === 1'b1) wr_hi++;
         @(negedge clk);
      end
      total++;
      if (done_hi != 0 || wr_hi != 0) begin
         bad++; $display("FAIL rstmid_quiet got done=%0d wr=%0d exp 0/0", done_hi, wr_hi);
      end
      test_basic();
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      cfg_base_addr = '0;
      cfg_stride    = '0;
      cfg_rows      = '0;
      cfg_relu      = 1'b0;
      result_valid  = 1'b0;
      result_data   = '0;
      mem_wr_ready  = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_rows();
      test_relu();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Receiving end of the systolic array result stream. It accepts result rows over the `result_valid`/`result_ready` handshake and buffers them in a small row FIFO. It then writes each row as one word to the output/accumulator SRAM at `base + row*stride`. It replaces the bench-side capture loop with synthesizable RTL that applies backpressure to the array whenever the SRAM port stalls.

## Interface
- `ARRAY_SIZE`, 4, lanes per result row
- `ACC_WIDTH`, 32, bits per lane (signed)
- `ADDR_WIDTH`, 10, SRAM word address width
- `FIFO_DEPTH`, 4, row buffer depth (power of two, ≥2)

- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begin a drain job; sampled only in IDLE
- `cfg_base_addr`  input  ADDR_WIDTH  first row address; latched on start
- `cfg_stride`  input  ADDR_WIDTH  address increment per row; latched on start
- `cfg_rows`  input  16  rows to accept; latched on start
- `cfg_relu`  input  1  ReLU select; latched on start (see Configuration)
- `busy`  output  1  high in RUN and FLUSH
- `done`  output  1  one-cycle pulse when the job completes
- `result_valid`  input  1  array offers a row
- `result_data`  input  ARRAY_SIZE*ACC_WIDTH  lane c at `[c*ACC_WIDTH +: ACC_WIDTH]`
- `result_ready`  output  1  drain accepts the row this cycle
- `mem_wr_en`  output  1  write request
- `mem_wr_addr`  output  ADDR_WIDTH  write address
- `mem_wr_data`  output  ARRAY_SIZE*ACC_WIDTH  write row, same lane packing
- `mem_wr_ready`  input  1  SRAM accepts the write this cycle

## Operation
- States:
  - IDLE → RUN on `start`. Latch the cfg inputs and clear the accept and write counters.
  - RUN → FLUSH when accepted count reaches `cfg_rows`.
  - FLUSH → DONE when written count reaches `cfg_rows` and the FIFO is empty.
  - DONE → IDLE unconditionally. `done`=1 for exactly this cycle.
- `start` with `cfg_rows`=0: IDLE→RUN→FLUSH→DONE with no handshakes. `done` pulses 3 cycles after `start`.
- `result_ready` = (state==RUN) && FIFO not full && accepted < `cfg_rows`. It is combinational from registered state only and does not depend on `result_valid`.
- Accept = `result_valid && result_ready`. Each accept pushes a row and increments the accepted count.
- FIFO is show-ahead:
  - `mem_wr_en` = FIFO not empty; `mem_wr_data` = FIFO head.
  - `mem_wr_addr` = `base + written*stride`, truncated to ADDR_WIDTH, so addresses wrap modulo 2^ADDR_WIDTH.
- Write = `mem_wr_en && mem_wr_ready`. Each write pops the FIFO and increments the written count.
- Push and pop in the same cycle are both honoured and occupancy is unchanged. A push while full is impossible because `result_ready` is low.
- `result_valid` outside RUN is ignored; no push occurs.
- `start` while busy or in DONE is ignored.
- Reset mid-job:
  - State returns to IDLE and the FIFO is emptied; any un-written rows are discarded.
  - Counters clear and no `done` is generated.
- Row order is preserved: row i is written at `base + i*stride`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `result_ready`=0
  - `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0
- `busy` rises the cycle after `start` is sampled.
- Accept-to-write latency: a row accepted at edge t drives `mem_wr_en` in the cycle after t, provided the FIFO was empty.
- Sustained throughput is 1 row/cycle with `mem_wr_ready` held at 1.
- With `mem_wr_ready`=0, `result_ready` drops in the cycle after the FIFO reaches FIFO_DEPTH entries.
- `done` asserts the cycle after the final write edge.

## Configuration
- `RESULT_DRAIN_RELU_EN` defined: when the latched `cfg_relu`=1, every lane with its sign bit set is written as 0 and other lanes pass unchanged. The clamp is applied on the FIFO output path and adds no latency.
- Not defined: `cfg_relu` is ignored and data is written bit-exact. No ReLU logic is synthesized.

## Test plan
- Basic drain: base=0x010, stride=1, rows=4; rows {1,2,3,4} in all lanes, `mem_wr_ready`=1.
  - Expect writes to 0x010..0x013 with matching data.
  - Expect `done` 1 cycle after the 4th write.
  - Expect `busy` low the cycle after `done`.
- Backpressure: rows=8, `mem_wr_ready`=0 for 10 cycles, `result_valid` held high.
  - Expect exactly 4 accepts, then `result_ready`=0.
  - After `mem_wr_ready`=1, expect all 8 rows written in order with none lost or duplicated.
- Stride and wrap: ADDR_WIDTH=10, base=0x3FE, stride=2, rows=3 → addresses 0x3FE, 0x000, 0x002.
- Zero rows: `start` with rows=0 → `done` 3 cycles after `start`, no `mem_wr_en`, `result_ready` never high.
- ReLU (macro defined, `cfg_relu`=1): lanes {-5, 7, 0x80000000, 0} → written {0, 7, 0, 0}. Same stimulus with `cfg_relu`=0 → bit-exact.
- Reset mid-job: `rst` for 1 cycle after 2 of 4 rows are accepted and nothing written (`mem_wr_ready`=0).
  - Expect all outputs at reset values the next cycle and no `done`.
  - A new job then completes normally.
